// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding selects and load-use stall for the
// pipelined MIPS core. Shadows the EX/MEM/WB destination tags internally,
// fed from the ID-stage decode, so the datapath does not feed rd/RegWrite
// back into this block.
// Optional build macro FWD_WB2_EN adds a WB2 tag slot and forward code 2'b11,
// which forwards from the register-file write-back latch. Use it for a
// register file that lacks write-before-read.
module fwd_hazard_unit #(
  parameter int REG_AW  = 3,
  parameter int NUM_SRC = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic                        id_reg_write,
  input  logic                        id_mem_read,
  input  logic                        flush,
  input  logic                        ext_stall,
  output logic                        stall_id,
  output logic                        ex_valid,
  output logic [NUM_SRC*2-1:0]        fwd_sel
);

  // Control bits of each slot. Reset clears these.
  logic                      ex_v_q,   ex_v_d;
  logic                      ex_rw_q,  ex_rw_d;
  logic                      ex_ld_q,  ex_ld_d;
  logic                      mem_v_q,  mem_v_d;
  logic                      mem_rw_q, mem_rw_d;
  logic                      mem_ld_q, mem_ld_d;
  logic                      wb_v_q,   wb_v_d;
  logic                      wb_rw_q,  wb_rw_d;
  // Tag/data bits of each slot. These are only meaningful while v is set.
  logic [NUM_SRC*REG_AW-1:0] ex_src_q,  ex_src_d;
  logic [NUM_SRC-1:0]        ex_used_q, ex_used_d;
  logic [REG_AW-1:0]         ex_rd_q,   ex_rd_d;
  logic [REG_AW-1:0]         mem_rd_q,  mem_rd_d;
  logic [REG_AW-1:0]         wb_rd_q,   wb_rd_d;
`ifdef FWD_WB2_EN
  logic                      wb2_v_q,  wb2_v_d;
  logic                      wb2_rw_q, wb2_rw_d;
  logic [REG_AW-1:0]         wb2_rd_q, wb2_rd_d;
`endif

  logic ex_take;
  logic src_hit;

  // Load-use detection: a load in EX whose destination is read by the ID instruction.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == ex_rd_q)) src_hit = 1'b1;
    end
    stall_id = id_valid & ex_v_q & ex_ld_q & ex_rw_q & (ex_rd_q != '0) & src_hit;
  end

  // Per-source forward select for the EX instruction. The youngest producer wins.
  // A load sitting in MEM is never a forward source; stall_id keeps that case from arising.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_v_q && ex_used_q[i]) begin
        if (mem_v_q && mem_rw_q && (mem_rd_q != '0) && !mem_ld_q &&
            (mem_rd_q == ex_src_q[i*REG_AW +: REG_AW]))
          fwd_sel[2*i +: 2] = 2'b01;
        else if (wb_v_q && wb_rw_q && (wb_rd_q != '0) &&
                 (wb_rd_q == ex_src_q[i*REG_AW +: REG_AW]))
          fwd_sel[2*i +: 2] = 2'b10;
`ifdef FWD_WB2_EN
        else if (wb2_v_q && wb2_rw_q && (wb2_rd_q != '0) &&
                 (wb2_rd_q == ex_src_q[i*REG_AW +: REG_AW]))
          fwd_sel[2*i +: 2] = 2'b11;
`endif
      end
    end
  end

  assign ex_valid = ex_v_q;

  // Slot advance. ext_stall freezes every slot. A stalled or flushed ID instruction enters EX as a bubble.
  always_comb begin
    ex_take   = id_valid & ~stall_id & ~flush;
    ex_v_d    = ex_v_q;    ex_rw_d  = ex_rw_q;  ex_ld_d  = ex_ld_q;
    ex_src_d  = ex_src_q;  ex_used_d = ex_used_q; ex_rd_d = ex_rd_q;
    mem_v_d   = mem_v_q;   mem_rw_d = mem_rw_q; mem_ld_d = mem_ld_q; mem_rd_d = mem_rd_q;
    wb_v_d    = wb_v_q;    wb_rw_d  = wb_rw_q;  wb_rd_d  = wb_rd_q;
`ifdef FWD_WB2_EN
    wb2_v_d   = wb2_v_q;   wb2_rw_d = wb2_rw_q; wb2_rd_d = wb2_rd_q;
`endif
    if (!ext_stall) begin
`ifdef FWD_WB2_EN
      wb2_v_d  = wb_v_q;   wb2_rw_d = wb_rw_q;  wb2_rd_d = wb_rd_q;
`endif
      wb_v_d    = mem_v_q;  wb_rw_d  = mem_rw_q; wb_rd_d  = mem_rd_q;
      mem_v_d   = ex_v_q;   mem_rw_d = ex_rw_q;  mem_ld_d = ex_ld_q;  mem_rd_d = ex_rd_q;
      ex_v_d    = ex_take;
      ex_rw_d   = ex_take & id_reg_write;
      ex_ld_d   = ex_take & id_mem_read;
      ex_src_d  = id_src;
      ex_used_d = id_src_used;
      ex_rd_d   = id_rd;
    end
  end

  // Control flops. An asynchronous reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q  <= 1'b0; ex_rw_q  <= 1'b0; ex_ld_q  <= 1'b0;
      mem_v_q <= 1'b0; mem_rw_q <= 1'b0; mem_ld_q <= 1'b0;
      wb_v_q  <= 1'b0; wb_rw_q  <= 1'b0;
`ifdef FWD_WB2_EN
      wb2_v_q <= 1'b0; wb2_rw_q <= 1'b0;
`endif
    end else begin
      ex_v_q  <= ex_v_d;  ex_rw_q  <= ex_rw_d;  ex_ld_q  <= ex_ld_d;
      mem_v_q <= mem_v_d; mem_rw_q <= mem_rw_d; mem_ld_q <= mem_ld_d;
      wb_v_q  <= wb_v_d;  wb_rw_q  <= wb_rw_d;
`ifdef FWD_WB2_EN
      wb2_v_q <= wb2_v_d; wb2_rw_q <= wb2_rw_d;
`endif
    end
  end

  // Tag flops. They are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    ex_src_q  <= ex_src_d;
    ex_used_q <= ex_used_d;
    ex_rd_q   <= ex_rd_d;
    mem_rd_q  <= mem_rd_d;
    wb_rd_q   <= wb_rd_d;
`ifdef FWD_WB2_EN
    wb2_rd_q  <= wb2_rd_d;
`endif
  end

endmodule
